// File: rtl/loadable_counter_if.sv
// Bus bundle for loadable_counter: load/enable/data controls in, registered count out.
interface loadable_counter_if #(
    parameter int WIDTH = 5
);
    logic             load;
    logic             enab;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;

    modport master (
        output load,
        output enab,
        output cnt_in,
        input  cnt_out
    );

    modport slave (
        input  load,
        input  enab,
        input  cnt_in,
        output cnt_out
    );
endinterface

// File: rtl/loadable_counter.sv
// Parameterised up-counter with parallel load (load beats enable), modulo 2^WIDTH
// wrap and asynchronous active-low clear. The count output is taken straight from the register.
module loadable_counter #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    loadable_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next-count selection: load first, then increment, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.load == 1'b1) begin
            cnt_d = bus.cnt_in;
        end else if (bus.enab == 1'b1) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt_out = cnt_q;

endmodule

// File: tb/tb_loadable_counter.sv
// Directed bench for loadable_counter: vector table plus reset/count-run sequences.
module tb_loadable_counter;

    localparam int W = 5;

    typedef struct {
        logic         load;
        logic         enab;
        logic [W-1:0] cnt_in;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    vec_t vecs [11];

    loadable_counter_if #(.WIDTH(W)) bus ();

    loadable_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: cnt_out=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic en, input logic [W-1:0] din);
        bus.load   = ld;
        bus.enab   = en;
        bus.cnt_in = din;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{1'b1, 1'b1, 5'h15, 5'h15, "load_15"};
        vecs[1]  = '{1'b1, 1'b1, 5'h0A, 5'h0A, "load_0a"};
        vecs[2]  = '{1'b1, 1'b1, 5'h1F, 5'h1F, "load_1f"};
        vecs[3]  = '{1'b0, 1'b1, 5'h03, 5'h00, "wrap"};
        vecs[4]  = '{1'b0, 1'b1, 5'h03, 5'h01, "after_wrap"};
        vecs[5]  = '{1'b1, 1'b0, 5'h07, 5'h07, "load_07"};
        vecs[6]  = '{1'b0, 1'b0, 5'h1F, 5'h07, "hold_1"};
        vecs[7]  = '{1'b0, 1'b0, 5'h00, 5'h07, "hold_2"};
        vecs[8]  = '{1'b0, 1'b0, 5'h12, 5'h07, "hold_3"};
        vecs[9]  = '{1'b0, 1'b1, 5'h1F, 5'h08, "inc_after_hold"};
        vecs[10] = '{1'b1, 1'b0, 5'h15, 5'h15, "load_15_again"};

        // Power-up reset
        rst = 1'b0;
        drive(1'b0, 1'b0, 5'h00);
        @(posedge clk);
        #1;
        check("reset_state", bus.cnt_out, 5'h00);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].load, vecs[i].enab, vecs[i].cnt_in);
            @(posedge clk);
            #1;
            check(vecs[i].name, bus.cnt_out, vecs[i].exp);
            @(negedge clk);
        end

        // Asynchronous reset between edges with count at 0x15
        drive(1'b1, 1'b0, 5'h1F);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", bus.cnt_out, 5'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("held_in_reset", bus.cnt_out, 5'h00);
        end

        // Release with load pending: loads on the very first edge
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reload_after_reset", bus.cnt_out, 5'h1F);

        // Count run from zero after reset release
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 5'h00);
        #1;
        check("reset_before_run", bus.cnt_out, 5'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("count_run_%0d", i), bus.cnt_out, W'(i));
            @(negedge clk);
        end

        // Short reset pulse between edges discards the pending increment
        #1;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("pulse_clear", bus.cnt_out, 5'h00);
        @(posedge clk);
        #1;
        check("inc_after_pulse", bus.cnt_out, 5'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
